// File: rtl/side_buffer_pkg.sv
// Shared flit type, side-buffer defaults and starvation FSM encodings.
// Imported by the side buffer and its starvation counter.
package side_buffer_pkg;

  localparam int WIDTH_FLIT_INT  = 32;
  localparam int SIDE_BUF_DEPTH  = 4;
  localparam int SIDE_BUF_STARVE = 2;

  typedef logic [WIDTH_FLIT_INT-1:0] flit_int_t;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_STARVED = 2'd2;

  // Same AND-mask style the router uses to blank unused channels.
  function automatic flit_int_t mask_flit(input flit_int_t f, input logic v);
    return f & {WIDTH_FLIT_INT{v}};
  endfunction

endpackage

// File: rtl/sb_starve_ctr.sv
// Head-of-line wait tracker: saturating counter plus IDLE/WAIT/STARVED state.
// Requests a redirection once the head has waited STARVE_LIMIT cycles.
import side_buffer_pkg::*;

module sb_starve_ctr #(
  parameter int STARVE_LIMIT = SIDE_BUF_STARVE
) (
  input  logic clk,
  input  logic rst,
  input  logic i_empty,
  input  logic i_empty_next,
  input  logic i_pop,
  output logic o_redirect_req
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  logic [SW-1:0] r_cnt;
  logic [SW-1:0] w_cnt_next;
  logic [1:0]    r_state;
  logic [1:0]    w_state_next;

  always_comb begin
    w_cnt_next = r_cnt;
    if (i_empty || i_pop) begin
      w_cnt_next = '0;
    end else if (r_cnt != LIMIT_C) begin
      w_cnt_next = r_cnt + SW'(1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (i_empty_next) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:             w_state_next = ST_WAIT;
        // A pop hands the slot to a new head, whose wait starts from zero.
        ST_WAIT, ST_STARVED: w_state_next = (!i_pop && w_cnt_next == LIMIT_C) ? ST_STARVED : ST_WAIT;
        default:             w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_state <= ST_IDLE;
    end else begin
      r_cnt   <= w_cnt_next;
      r_state <= w_state_next;
    end
  end

  assign o_redirect_req = (r_state == ST_STARVED) && (r_cnt == LIMIT_C) && !i_empty;

endmodule

// File: rtl/side_buffer.sv
// MinBD side buffer: small FIFO holding flits pulled off the permutation path
// until a channel frees up, with a starvation-driven redirection request.
import side_buffer_pkg::*;

module side_buffer #(
  parameter int DEPTH        = SIDE_BUF_DEPTH,
  parameter int STARVE_LIMIT = SIDE_BUF_STARVE
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  flit_int_t                  din,
  input  logic                       rd_en,
  output flit_int_t                  dout,
  output logic                       dout_valid,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       redirect_req,
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  flit_int_t     r_mem [DEPTH];
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_wptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic          r_overflow;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == DEPTH_C);
  assign w_pop   = rd_en && !w_empty;
  // When full, a same-cycle pop frees the slot this push lands in.
  assign w_push  = wr_en && (!w_full || w_pop);

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + CW'(1);
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rptr     <= '0;
      r_wptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      r_count <= w_count_next;
      if (wr_en && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  sb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk            (clk),
    .rst            (reset),
    .i_empty        (w_empty),
    .i_empty_next   (w_count_next == '0),
    .i_pop          (w_pop),
    .o_redirect_req (redirect_req)
  );

  assign dout       = mask_flit(r_mem[r_rptr], !w_empty);
  assign dout_valid = !w_empty;
  assign full       = w_full;
  assign count      = r_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_side_buffer.sv
// Directed bench for side_buffer: a queue scoreboard holds the flits expected
// at the head, and every cycle's outputs are compared against it.
import side_buffer_pkg::*;

module tb_side_buffer;

  localparam int DEPTH = 4;

  logic       clk;
  logic       reset;
  logic       wr_en;
  flit_int_t  din;
  logic       rd_en;
  flit_int_t  dout;
  logic       dout_valid;
  logic       full;
  logic [2:0] count;
  logic       redirect_req;
  logic       overflow;

  int        checks = 0;
  int        errors = 0;
  int        txn    = 0;
  flit_int_t q[$];
  logic      m_ovf  = 1'b0;

  side_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .full         (full),
    .count        (count),
    .redirect_req (redirect_req),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    flit_int_t head;
    head = (q.size() != 0) ? q[0] : '0;
    check("count",      64'(count),      64'(q.size()));
    check("dout_valid", 64'(dout_valid), 64'(q.size() != 0));
    check("full",       64'(full),       64'(q.size() == DEPTH));
    check("overflow",   64'(overflow),   64'(m_ovf));
    check("dout",       64'(dout),       64'(head));
  endtask

  // One clock of stimulus; the scoreboard is updated with what the buffer must accept.
  task automatic cycle(input logic we, input flit_int_t d, input logic re);
    logic      pop;
    logic      push;
    flit_int_t tmp;
    wr_en = we;
    din   = d;
    rd_en = re;
    pop   = re && (q.size() != 0);
    push  = we && ((q.size() < DEPTH) || pop);
    if (we && !push) m_ovf = 1'b1;
    if (pop) tmp = q.pop_front();
    if (push) q.push_back(d);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
    txn++;
    $display("txn %0d we=%0b re=%0b din=%h count=%0d dout=%h redir=%0b",
             txn, we, re, d, count, dout, redirect_req);
    check_state();
  endtask

  initial begin
    flit_int_t v;
    reset = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;

    // Reset asserted between edges, then idle.
    #7 reset = 1'b1;
    #1;
    check_state();
    check("rst_redirect", 64'(redirect_req), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (5) begin
      cycle(1'b0, '0, 1'b0);
      check("idle_redirect", 64'(redirect_req), 64'(0));
    end

    // Basic order: A, B, C in, then out.
    cycle(1'b1, 32'hA0A0_0001, 1'b0);
    cycle(1'b1, 32'hB0B0_0002, 1'b0);
    cycle(1'b1, 32'hC0C0_0003, 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b1);

    // Full buffer with push and pop together.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, flit_int_t'(32'h1000 + i), 1'b0);
    cycle(1'b1, 32'hEEEE_0005, 1'b1);
    repeat (DEPTH) cycle(1'b0, '0, 1'b1);
    // Empty buffer with push and pop together: pop ignored.
    cycle(1'b1, 32'hF00D_0006, 1'b1);
    cycle(1'b0, '0, 1'b1);

    // Interleaved pairs wrap the pointers several times.
    for (int i = 0; i < 10; i++) begin
      v = $urandom;
      cycle(1'b1, v, 1'b0);
      cycle(1'b0, '0, 1'b1);
    end

    // Starvation: redirect two cycles after the head becomes valid.
    cycle(1'b1, 32'h5A5A_0007, 1'b0);
    check("starve_e1", 64'(redirect_req), 64'(0));
    cycle(1'b1, 32'h5A5A_0008, 1'b0);
    check("starve_e2", 64'(redirect_req), 64'(0));
    cycle(1'b0, '0, 1'b0);
    check("starve_e3", 64'(redirect_req), 64'(1));
    cycle(1'b0, '0, 1'b1);
    check("starve_pop", 64'(redirect_req), 64'(0));
    cycle(1'b0, '0, 1'b0);
    check("starve_new1", 64'(redirect_req), 64'(0));
    cycle(1'b0, '0, 1'b0);
    check("starve_new2", 64'(redirect_req), 64'(1));
    cycle(1'b0, '0, 1'b0);
    check("starve_hold", 64'(redirect_req), 64'(1));
    cycle(1'b0, '0, 1'b1);
    check("starve_empty", 64'(redirect_req), 64'(0));

    // Fill and overflow: fifth push is dropped, overflow sticks.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, flit_int_t'(32'h2000 + i), 1'b0);
    cycle(1'b1, 32'hDEAD_BEEF, 1'b0);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b1);

    // Reset mid-operation discards everything.
    @(negedge clk) reset = 1'b1;
    #1;
    q.delete();
    m_ovf = 1'b0;
    check_state();
    check("midrst_redirect", 64'(redirect_req), 64'(0));
    @(negedge clk) reset = 1'b0;
    repeat (3) begin
      cycle(1'b0, '0, 1'b1);
      check("post_rst_redirect", 64'(redirect_req), 64'(0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
